// File: rtl/btn_step_conditioner.sv
// ============================================================================
// Module   : btn_step_conditioner
// Brief    : Two-button synchroniser/debouncer producing one-cycle step pulses
//            B_UP / B_DOWN and debounced level flags. Optional macro
//            AUTO_REPEAT_EN adds hold-to-repeat pulses while a button is held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_step_conditioner #(
  parameter int DEB_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic B_UP,
  output logic B_DOWN,
  output logic up_held,
  output logic down_held
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam longint MAX_DH  = (DEB_CYCLES > HOLD_CYCLES) ? longint'(DEB_CYCLES) : longint'(HOLD_CYCLES);
  localparam longint MAX_ALL = (MAX_DH > longint'(REPEAT_CYCLES)) ? MAX_DH : longint'(REPEAT_CYCLES);

  // Every counter terminal value must be representable in CNT_W bits.
  if (DEB_CYCLES < 2 || (MAX_ALL - 1) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("btn_step_conditioner: DEB_CYCLES < 2 or CNT_W too narrow");
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0] raw;
  logic [1:0] sync_meta;
  logic [1:0] sync_s;
  wire  [1:0] cand;
  wire  [1:0] held;

  assign raw = {btn_down_raw, btn_up_raw};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 2'b00;
      sync_s    <= 2'b00;
    end else begin
      sync_meta <= raw;
      sync_s    <= sync_meta;
    end
  end

  // Index 0 is the up button, index 1 the down button.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_cand;
    logic             s;

    assign s = sync_s[i];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      press_cand = 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt  = PRESSED;
            cnt_nxt    = '0;
            press_cand = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high resumes PRESSED silently: no second pulse.
          if (s) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             repeating;
    logic             rep_cand;

    assign rep_cand = (state == PRESSED) &&
                      (hold_cnt == (repeating ? REPEAT_LAST : HOLD_LAST));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (state == PRESSED && state_nxt == PRESSED) begin
        if (rep_cand) begin
          hold_cnt  <= '0;
          repeating <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + CNT_ONE;
        end
      end else begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end
    end

    assign cand[i] = press_cand | rep_cand;
`else
    assign cand[i] = press_cand;
`endif

    assign held[i] = (state == PRESSED) || (state == RELEASE_WAIT);
  end

  // Coincident candidates cancel so the selector never sees both directions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      B_UP   <= 1'b0;
      B_DOWN <= 1'b0;
    end else begin
      B_UP   <= cand[0] & ~cand[1];
      B_DOWN <= cand[1] & ~cand[0];
    end
  end

  assign up_held   = held[0];
  assign down_held = held[1];

endmodule

`default_nettype wire

// File: tb/tb_btn_step_conditioner.sv
// ============================================================================
// Module   : tb_btn_step_conditioner
// Brief    : Directed self-checking bench for btn_step_conditioner
//            (DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_step_conditioner;

  logic clock;
  logic reset;
  logic btn_up_raw;
  logic btn_down_raw;
  logic B_UP;
  logic B_DOWN;
  logic up_held;
  logic down_held;

  int total;
  int bad;

  btn_step_conditioner #(
    .DEB_CYCLES   (4),
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(8),
    .CNT_W        (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_up_raw  (btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .B_UP        (B_UP),
    .B_DOWN      (B_DOWN),
    .up_held     (up_held),
    .down_held   (down_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] at_edge(input int e);
    return 64'd1 << e;
  endfunction

  function automatic logic [63:0] from_edge(input int e);
    return ~64'd0 << e;
  endfunction

  function automatic logic [63:0] below_edge(input int e);
    return ~(~64'd0 << e);
  endfunction

  // Runs n edges (numbered from 0) and checks all outputs after each edge;
  // bit e of each mask is the value required just after edge e.
  task automatic watch(input string name, input int n,
                       input logic [63:0] up_m, input logic [63:0] dn_m,
                       input logic [63:0] uh_m, input logic [63:0] dh_m);
    for (int e = 0; e < n; e++) begin
      tick();
      check($sformatf("%s B_UP e%0d", name, e), {31'd0, B_UP}, {31'd0, up_m[e]});
      check($sformatf("%s B_DOWN e%0d", name, e), {31'd0, B_DOWN}, {31'd0, dn_m[e]});
      check($sformatf("%s up_held e%0d", name, e), {31'd0, up_held}, {31'd0, uh_m[e]});
      check($sformatf("%s down_held e%0d", name, e), {31'd0, down_held}, {31'd0, dh_m[e]});
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " B_UP"}, {31'd0, B_UP}, 32'd0);
    check({name, " B_DOWN"}, {31'd0, B_DOWN}, 32'd0);
    check({name, " up_held"}, {31'd0, up_held}, 32'd0);
    check({name, " down_held"}, {31'd0, down_held}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] up_first;
    logic [3:0]  bounce;
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    bounce       = 4'b0101;

    #2;
    check_all_zero("in_reset");
    tick();
    tick();
    reset = 1'b0;
    watch("idle", 3, 64'd0, 64'd0, 64'd0, 64'd0);

    // Single up press held 30 cycles.
`ifdef AUTO_REPEAT_EN
    up_first = at_edge(5) | at_edge(25);
`else
    up_first = at_edge(5);
`endif
    btn_up_raw = 1'b1;
    watch("up_press", 30, up_first, 64'd0, from_edge(5), 64'd0);
    btn_up_raw = 1'b0;
    watch("up_release", 8, 64'd0, 64'd0, below_edge(5), 64'd0);

    // Bouncing down button, then stable high.
    for (int b = 0; b < 4; b++) begin
      btn_down_raw = bounce[b];
      watch("dn_bounce", 1, 64'd0, 64'd0, 64'd0, 64'd0);
    end
    btn_down_raw = 1'b1;
    watch("dn_stable", 12, 64'd0, at_edge(5), 64'd0, from_edge(5));
    btn_down_raw = 1'b0;
    watch("dn_release", 8, 64'd0, 64'd0, 64'd0, below_edge(5));

    // Both buttons together: pulses cancel, levels still track.
    btn_up_raw   = 1'b1;
    btn_down_raw = 1'b1;
    watch("both", 12, 64'd0, 64'd0, from_edge(5), from_edge(5));
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    watch("both_rel", 8, 64'd0, 64'd0, below_edge(5), below_edge(5));

    // Accepted press, 2-cycle low glitch, release, re-press.
    btn_up_raw = 1'b1;
    watch("gl_press", 10, at_edge(5), 64'd0, from_edge(5), 64'd0);
    btn_up_raw = 1'b0;
    watch("gl_low", 2, 64'd0, 64'd0, ~64'd0, 64'd0);
    btn_up_raw = 1'b1;
    watch("gl_back", 6, 64'd0, 64'd0, ~64'd0, 64'd0);
    btn_up_raw = 1'b0;
    watch("gl_release", 8, 64'd0, 64'd0, below_edge(5), 64'd0);
    btn_up_raw = 1'b1;
    watch("gl_repress", 8, at_edge(5), 64'd0, from_edge(5), 64'd0);
    btn_up_raw = 1'b0;
    watch("gl_rerel", 8, 64'd0, 64'd0, below_edge(5), 64'd0);

    // Asynchronous reset while the pulse is high; button held through reset.
    btn_up_raw = 1'b1;
    watch("rst_press", 6, at_edge(5), 64'd0, from_edge(5), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    reset = 1'b0;
    watch("rst_held", 8, at_edge(5), 64'd0, from_edge(5), 64'd0);
    btn_up_raw = 1'b0;
    watch("rst_rel", 8, 64'd0, 64'd0, below_edge(5), 64'd0);

`ifdef AUTO_REPEAT_EN
    btn_up_raw = 1'b1;
    watch("ar_hold", 50, at_edge(5) | at_edge(25) | at_edge(33) | at_edge(41) | at_edge(49),
          64'd0, from_edge(5), 64'd0);
    btn_up_raw = 1'b0;
    watch("ar_rel", 8, 64'd0, 64'd0, below_edge(5), 64'd0);
    btn_up_raw = 1'b1;
    watch("ar_pre_rst", 31, at_edge(5) | at_edge(25), 64'd0, from_edge(5), 64'd0);
    reset      = 1'b1;
    btn_up_raw = 1'b0;
    #1;
    check_all_zero("ar_rst");
    tick();
    reset = 1'b0;
    watch("ar_post_rst", 25, 64'd0, 64'd0, 64'd0, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btn_step_conditioner.md
Name: btn_step_conditioner

Overview:
- Upstream stage of the frequency up/down selector.
- Takes two raw push-button inputs, synchronises and debounces each, and produces single-cycle step pulses B_UP / B_DOWN for the selector.
- Guarantees at most one step pulse per debounced press, and never both pulses in the same cycle.
- Exports debounced level flags for status LEDs.

Parameters:
- DEB_CYCLES, 500000, consecutive stable synchronised samples required to accept a press or release (10 ms at 50 MHz); minimum 2.
- HOLD_CYCLES, 25000000, cycles in PRESSED before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
- REPEAT_CYCLES, 10000000, cycles between subsequent auto-repeat pulses (used only with AUTO_REPEAT_EN).
- CNT_W, 25, width of each per-button counter; must hold max(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) - 1.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- btn_up_raw  input  1  raw, asynchronous, bouncing "up" button (1 = pressed)
- btn_down_raw  input  1  raw, asynchronous, bouncing "down" button (1 = pressed)
- B_UP  output  1  registered one-cycle step-up pulse
- B_DOWN  output  1  registered one-cycle step-down pulse
- up_held  output  1  debounced level of up button (1 in PRESSED or RELEASE_WAIT)
- down_held  output  1  debounced level of down button

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-high.
  - On reset: sync flops = 0, both FSMs = IDLE, counters = 0, B_UP = B_DOWN = up_held = down_held = 0.
- Synchroniser: each raw input passes through 2 flops; the second flop is the sample s used below.
- Per-button FSM (identical instance for up and down), states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: s=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT: s=0 -> IDLE, cnt=0; s=1 and cnt==DEB_CYCLES-1 -> PRESSED, raise candidate pulse; otherwise cnt+1.
  - PRESSED: s=0 -> RELEASE_WAIT, cnt=1; else stay.
  - RELEASE_WAIT: s=1 -> PRESSED, cnt=0, no pulse; s=0 and cnt==DEB_CYCLES-1 -> IDLE, cnt=0; otherwise cnt+1.
  - No pulse is ever generated on release.
- Latency: raw held stable high before edge 0 -> pulse output high from edge DEB_CYCLES+1 to edge DEB_CYCLES+2. Exactly one cycle wide.
- Simultaneous events: B_UP <= cand_up & ~cand_down; B_DOWN <= cand_down & ~cand_up. If both candidates fire in the same cycle, neither pulse is emitted. Presses on the other button are otherwise independent.
- Counter: saturating is not needed (bounded by FSM); width CNT_W, unsigned.
- Reset mid-operation: immediate return to reset values; any pending press is discarded.
  - A button still held when reset deasserts is treated as a new press: one pulse after DEB_CYCLES+2 cycles.
- Glitch shorter than DEB_CYCLES samples: no pulse, no level change.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- When defined:
  - In PRESSED, a hold counter increments each cycle.
  - At HOLD_CYCLES a candidate pulse fires and the counter reloads; further candidates fire every REPEAT_CYCLES while PRESSED.
  - The hold counter clears on entering RELEASE_WAIT or IDLE.
  - Repeat candidates obey the same simultaneous-suppression rule.
- When undefined: hold counter logic absent; exactly one pulse per accepted press; HOLD_CYCLES / REPEAT_CYCLES ignored.

Test Plan:
- Bench parameters for all scenarios: DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- btn_up_raw 0->1 before edge 0, held 30 cycles -> B_UP=1 only between edges 5 and 6; up_held=1 from edge 5; B_DOWN stays 0. Without AUTO_REPEAT_EN there are no further pulses.
- btn_down_raw bounces 1,0,1,0 on alternate cycles, then stable 1 -> no pulse during bouncing; exactly one B_DOWN pulse 6 edges after the stable-high start.
- Both raw inputs rise on the same edge and are held -> B_UP=0 and B_DOWN=0 throughout; up_held=down_held=1 from edge 5.
- Up pressed and accepted, then 2-cycle low glitch -> up_held remains 1, no extra pulse. Release held low 4 samples -> up_held=0; re-press gives a new pulse.
- With AUTO_REPEAT_EN, up held 50 cycles -> pulses at edges 5, 25, 33, 41, 49; reset at edge 30 cancels the remaining pulses.
